// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO controllers: pointer width,
// Gray/binary conversion and the read-side output-stage action encoding.
package fifo_pkg;

  localparam int unsigned CONV_W = 32;

  typedef enum logic [1:0] {
    OUT_HOLD  = 2'd0,
    OUT_LOAD  = 2'd1,
    OUT_DRAIN = 2'd2
  } out_action_e;

  function automatic int unsigned ptr_aw(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
    logic [CONV_W-1:0] b;
    b[CONV_W-1] = g[CONV_W-1];
    for (int i = CONV_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Multi-flop synchronizer for a Gray pointer crossing into the local clock.
// Stages are pure flop-to-flop; nothing sits between them.
module fifo_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] stage_d [SYNC_STAGES];
  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  // Shift path: each stage takes its predecessor, stage 0 takes the input.
  always_comb begin
    stage_d[0] = i_d;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign o_q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the asynchronous FIFO: write-pointer sync, read
// pointers, registered empty flag and a first-word-fall-through output stage.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int DATA_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          i_rd_clk,
  input  logic                          i_rd_rst,
  input  logic [$clog2(DEPTH):0]        i_g_wr_ptr,
  input  logic [DATA_WIDTH-1:0]         i_rd_data,
  output logic [$clog2(DEPTH):0]        o_b_rd_ptr,
  output logic [$clog2(DEPTH):0]        o_g_rd_ptr,
  output logic                          o_rd_en,
  output logic                          o_empty,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic                          o_valid,
  input  logic                          i_ready
);

  localparam int AW = int'(ptr_aw(DEPTH));
  localparam int PW = AW + 1;

  logic [PW-1:0]         wq_s;
  logic                  rd_en_s;
  out_action_e           act_s;

  logic [PW-1:0]         b_ptr_d, b_ptr_q;
  logic [PW-1:0]         g_ptr_d, g_ptr_q;
  logic                  empty_d, empty_q;
  logic                  valid_d, valid_q;
  logic [DATA_WIDTH-1:0] data_d, data_q;

  fifo_sync #(
    .WIDTH       (PW),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_wr_ptr_sync (
    .i_clk (i_rd_clk),
    .i_rst (i_rd_rst),
    .i_d   (i_g_wr_ptr),
    .o_q   (wq_s)
  );

  // Pop whenever a word exists and the output stage is free or being drained.
  always_comb begin
    rd_en_s = ~empty_q & (~valid_q | i_ready);
  end

  // Pointer advance and empty look-ahead: the comparison uses the pointer
  // value about to be registered, so a pop is reflected on the same edge.
  always_comb begin
    b_ptr_d = b_ptr_q + {{AW{1'b0}}, rd_en_s};
    g_ptr_d = PW'(bin2gray(CONV_W'(b_ptr_d)));
    empty_d = (g_ptr_d == wq_s);
  end

  // Select what the output stage does this cycle.
  always_comb begin
    act_s = OUT_HOLD;
    if (rd_en_s) begin
      act_s = OUT_LOAD;
    end else if (valid_q && i_ready) begin
      act_s = OUT_DRAIN;
    end else begin
      act_s = OUT_HOLD;
    end
  end

  // Output-stage next state; a drain keeps the old data visible but invalid.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    case (act_s)
      OUT_LOAD: begin
        data_d  = i_rd_data;
        valid_d = 1'b1;
      end
      OUT_DRAIN: begin
        valid_d = 1'b0;
      end
      default: begin
        data_d  = data_q;
        valid_d = valid_q;
      end
    endcase
  end

  // State registers; reset drops any held word and reports empty.
  always_ff @(posedge i_rd_clk) begin
    if (i_rd_rst) begin
      b_ptr_q <= {PW{1'b0}};
      g_ptr_q <= {PW{1'b0}};
      empty_q <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      b_ptr_q <= b_ptr_d;
      g_ptr_q <= g_ptr_d;
      empty_q <= empty_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_b_rd_ptr = b_ptr_q;
  assign o_g_rd_ptr = g_ptr_q;
  assign o_rd_en    = rd_en_s;
  assign o_empty    = empty_q;
  assign o_valid    = valid_q;
  assign o_data     = data_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: a behavioural writer plus memory and a
// word-queue scoreboard for the consumer side.
module tb_fifo_rd_ctrl;

  localparam int DEPTH = 8;
  localparam int DW    = 4;
  localparam int SS    = 2;
  localparam int AW    = 3;
  localparam int PW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] g_wr;
  logic [DW-1:0] rd_data;
  logic [PW-1:0] b_rd, g_rd;
  logic          rd_en, empty, valid, ready;
  logic [DW-1:0] data;
  logic [DW-1:0] mem [DEPTH];

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;

  always #5 clk = ~clk;

  assign rd_data = mem[b_rd[AW-1:0]];

  fifo_rd_ctrl #(
    .DEPTH       (DEPTH),
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (SS)
  ) dut (
    .i_rd_clk   (clk),
    .i_rd_rst   (rst),
    .i_g_wr_ptr (g_wr),
    .i_rd_data  (rd_data),
    .o_b_rd_ptr (b_rd),
    .o_g_rd_ptr (g_rd),
    .o_rd_en    (rd_en),
    .o_empty    (empty),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready)
  );

  function automatic logic [PW-1:0] to_gray(input int n);
    logic [PW-1:0] b;
    b = PW'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; g_wr = '0; wr_cnt = 0; ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; g_wr = 4'd5; ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({b_rd, g_rd, empty, valid, data, rd_en} !== {4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0}) begin
        failures++;
        $display("FAIL reset_values cyc=%0d got b=%0d g=%0d empty=%0b valid=%0b data=%0h rd_en=%0b want 0 0 1 0 0 0",
                 i, b_rd, g_rd, empty, valid, data, rd_en);
      end
    end
    rst = 1'b0; g_wr = '0; wr_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({empty, valid} !== 2'b10) begin
        failures++;
        $display("FAIL reset_release cyc=%0d got empty=%0b valid=%0b want empty=1 valid=0", i, empty, valid);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    mem[0] = 4'hA; wr_cnt = 1; g_wr = to_gray(1); ready = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (valid !== 1'b0) begin
        failures++;
        $display("FAIL single_early edge=%0d got valid=%0b want 0", e, valid);
      end
    end
    tick();
    checks++;
    if ({valid, data, b_rd, empty} !== {1'b1, 4'hA, 4'd1, 1'b1}) begin
      failures++;
      $display("FAIL single_edge4 got valid=%0b data=%0h b=%0d empty=%0b want 1 a 1 1", valid, data, b_rd, empty);
    end
    tick();
    checks++;
    if ({valid, b_rd, empty} !== {1'b0, 4'd1, 1'b1}) begin
      failures++;
      $display("FAIL single_after got valid=%0b b=%0d empty=%0b want 0 1 1", valid, b_rd, empty);
    end
  endtask

  task automatic test_backpressure();
    int pops;
    int unstable;
    do_reset();
    for (int i = 0; i < 3; i++) mem[i] = DW'($urandom);
    wr_cnt = 3; g_wr = to_gray(3); ready = 1'b0;
    pops = 0; unstable = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (rd_en === 1'b1) pops++;
      if (valid === 1'b1 && data !== mem[0]) unstable++;
      tick();
    end
    checks++;
    if (pops != 1 || unstable != 0) begin
      failures++;
      $display("FAIL bp_pops got pops=%0d unstable=%0d want pops=1 unstable=0", pops, unstable);
    end
    checks++;
    if ({b_rd, valid, data} !== {4'd1, 1'b1, mem[0]}) begin
      failures++;
      $display("FAIL bp_hold got b=%0d valid=%0b data=%0h want 1 1 %0h", b_rd, valid, data, mem[0]);
    end
    ready = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      checks++;
      if ({valid, data} !== {1'b1, mem[k]}) begin
        failures++;
        $display("FAIL bp_release word=%0d got valid=%0b data=%0h want 1 %0h", k, valid, data, mem[k]);
      end
    end
    tick();
    checks++;
    if ({valid, b_rd, empty} !== {1'b0, 4'd3, 1'b1}) begin
      failures++;
      $display("FAIL bp_drained got valid=%0b b=%0d empty=%0b want 0 3 1", valid, b_rd, empty);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] q[$];
    logic [DW-1:0] w;
    logic [PW-1:0] prev_b, prev_g;
    int acc, popped, cyc;
    bit saw_wrap;
    do_reset();
    acc = 0; cyc = 0; saw_wrap = 1'b0; prev_b = '0; prev_g = '0;
    while ((wr_cnt < 24 || q.size() != 0) && cyc < 600) begin
      popped = acc + int'(valid);
      checks++;
      if (valid === 1'b1 && (q.size() == 0 || data !== q[0])) begin
        failures++;
        $display("FAIL wrap_data cyc=%0d got %0h want %0h", cyc, data, (q.size() != 0) ? q[0] : 4'h0);
      end
      checks++;
      if (b_rd !== PW'(popped) || g_rd !== to_gray(popped)) begin
        failures++;
        $display("FAIL wrap_ptr cyc=%0d got b=%0d g=%0h want b=%0d g=%0h", cyc, b_rd, g_rd, PW'(popped), to_gray(popped));
      end
      checks++;
      if ($countones(g_rd ^ prev_g) != ((b_rd != prev_b) ? 1 : 0)) begin
        failures++;
        $display("FAIL wrap_gray_step cyc=%0d got %0h->%0h want one-bit step per pop", cyc, prev_g, g_rd);
      end
      checks++;
      if (empty === 1'b0 && wr_cnt <= popped) begin
        failures++;
        $display("FAIL wrap_empty cyc=%0d got empty=0 with written=%0d popped=%0d want empty=1", cyc, wr_cnt, popped);
      end
      if (prev_b == 4'd15 && b_rd == 4'd0) saw_wrap = 1'b1;
      prev_b = b_rd; prev_g = g_rd;
      if (wr_cnt < 24 && (wr_cnt - popped) < DEPTH && $urandom_range(0, 3) != 0) begin
        w = DW'($urandom);
        mem[wr_cnt % DEPTH] = w;
        q.push_back(w);
        wr_cnt++;
        g_wr = to_gray(wr_cnt);
      end
      ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (empty === 1'b1 && rd_en !== 1'b0) begin
        failures++;
        $display("FAIL wrap_pop_empty cyc=%0d got rd_en=%0b want 0", cyc, rd_en);
      end
      if (valid === 1'b1 && ready) begin
        void'(q.pop_front());
        acc++;
      end
      tick();
      cyc++;
    end
    checks++;
    if (cyc >= 600 || acc != 24) begin
      failures++;
      $display("FAIL wrap_count got accepted=%0d cycles=%0d want 24 within 600", acc, cyc);
    end
    checks++;
    if (!saw_wrap) begin
      failures++;
      $display("FAIL wrap_rollover got no 15->0 pointer step want one");
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    int waited;
    do_reset();
    for (int i = 0; i < 5; i++) mem[i] = DW'($urandom);
    wr_cnt = 5; g_wr = to_gray(5); ready = 1'b0;
    waited = 0;
    while (valid !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    checks++;
    if (valid !== 1'b1 || b_rd !== 4'd1) begin
      failures++;
      $display("FAIL mid_prefill got valid=%0b b=%0d after %0d cycles want 1 1", valid, b_rd, waited);
    end
    rst = 1'b1; g_wr = '0; wr_cnt = 0;
    tick();
    checks++;
    if ({valid, empty, b_rd, g_rd, data} !== {1'b0, 1'b1, 4'd0, 4'd0, 4'd0}) begin
      failures++;
      $display("FAIL mid_reset got valid=%0b empty=%0b b=%0d g=%0d data=%0h want 0 1 0 0 0",
               valid, empty, b_rd, g_rd, data);
    end
    rst = 1'b0; ready = 1'b1; bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (valid !== 1'b0 || empty !== 1'b1 || rd_en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mid_release got %0d cycles with valid/pop/non-empty want 0", bad);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rst = 1'b1; g_wr = '0; ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-domain controller for the asynchronous FIFO. It sits between the dual-clock `fifo_mem` array and the downstream consumer. It synchronizes the Gray-coded write pointer into the read clock, keeps the read pointer and the registered empty flag, and drives the memory read address. It also presents each word through a registered valid/ready output stage, so the consumer sees a first-word-fall-through stream.

## Interface
- `DEPTH`, 8, FIFO depth; power of two, ≥ 2; must match `fifo_mem`.
- `DATA_WIDTH`, 4, word width; must match `fifo_mem`.
- `SYNC_STAGES`, 2, flops in the write-pointer synchronizer; ≥ 2.
- Derived: `AW = $clog2(DEPTH)`. Pointers are `AW+1` bits; the MSB is the wrap bit.

- `i_rd_clk` in 1: read-domain clock. This is the only clock.
- `i_rd_rst` in 1: synchronous, active-high reset.
- `i_g_wr_ptr` in AW+1: Gray write pointer from the write domain; asynchronous to `i_rd_clk`.
- `i_rd_data` in DATA_WIDTH: combinational memory output at `o_b_rd_ptr[AW-1:0]`.
- `o_b_rd_ptr` out AW+1: registered binary read pointer, to `fifo_mem`.
- `o_g_rd_ptr` out AW+1: registered Gray read pointer, to the write-domain synchronizer.
- `o_rd_en` out 1: pop strobe, to `fifo_mem` `i_rd_en`.
- `o_empty` out 1: registered empty flag, to `fifo_mem` `i_empty`.
- `o_data` out DATA_WIDTH: output-stage data.
- `o_valid` out 1: `o_data` holds a word.
- `i_ready` in 1: consumer accepts `o_data` this cycle.

## Operation
- **Synchronizer**
  - `i_g_wr_ptr` passes through `SYNC_STAGES` flops, all reset to 0.
  - `wq` is the last stage.
  - No logic is placed between stages.
- **Pop**
  - `o_rd_en = !o_empty && (!o_valid || i_ready)`. This is combinational.
  - `o_rd_en` never asserts while `o_empty` = 1.
- **Read pointer**
  - `b_next = o_b_rd_ptr + o_rd_en`, modulo 2^(AW+1).
  - `g_next = b_next ^ (b_next >> 1)`.
  - Both pointers register `b_next` and `g_next` every cycle.
- **Empty flag**
  - `o_empty <= (g_next == wq)`.
  - Full Gray comparison, including the MSB.
- **Output stage**
  - On `o_rd_en`: `o_data <= i_rd_data`, `o_valid <= 1`.
  - On `o_valid && i_ready && !o_rd_en`: `o_valid <= 0`, and `o_data` holds its value.
  - Otherwise `o_data` and `o_valid` hold.
- **Wrap-around**
  - The binary pointer rolls over from 2·DEPTH−1 to 0.
  - The address is the low `AW` bits.
  - The empty flag stays correct across the wrap because of the MSB.
- **Simultaneous accept and pop**
  - When `o_valid && i_ready` and `o_empty` = 0, the next word loads in the same edge.
  - `o_valid` stays 1, giving one word per cycle sustained.
- **Backpressure**
  - When `o_valid && !i_ready`, there is no pop.
  - The pointer, `o_data` and `o_valid` are all stable.
- **Reset, including mid-stream**
  - The synchronizer, both pointers and `o_data` go to 0.
  - `o_valid` goes to 0 and `o_empty` goes to 1.
  - Any held word is dropped.
  - The write side must be reset in the same window.

## Timing
- **Reset values:** `o_b_rd_ptr`=0, `o_g_rd_ptr`=0, `o_empty`=1, `o_valid`=0, `o_data`=0, `o_rd_en`=0.
- **Write-to-valid latency:** for a write-pointer change stable before rd edge R1:
  - `wq` updates at edge R(SYNC_STAGES).
  - `o_empty` falls at R(SYNC_STAGES+1).
  - `o_valid` rises at R(SYNC_STAGES+2), i.e. 4 edges at the default.
- **Pop-to-empty:** `o_empty` reflects a pop on the same edge the pointer advances; there is no extra lag on the read side.
- **Pessimism:** `o_empty` may stay 1 for up to `SYNC_STAGES` cycles after data exists. It never reads 0 while the FIFO is truly empty.
- **Memory read:** `i_rd_data` is assumed valid combinationally within the cycle `o_rd_en` is high.
- **Pointer change:** `o_g_rd_ptr` changes by exactly one bit per pop and is glitch-free, being a register output.

## Structure
- **Package `fifo_pkg`:**
  - `bin2gray` and `gray2bin` functions.
  - Pointer-width helper `AW = $clog2(DEPTH)`.
  - Shared with the write-side controller.
- **Sub-module `fifo_sync`:**
  - Parameterized `WIDTH` × `SYNC_STAGES` flop chain with synchronous reset.
  - Reused by the write controller for the read pointer.
- Remaining logic (pointer, empty, output stage) stays flat in `fifo_rd_ctrl`.

## Test plan
- **Reset:** hold `i_rd_rst`=1 for 3 cycles with `i_g_wr_ptr`=5 → all outputs at reset values; `o_empty`=1 throughout.
- **Single word:** `i_g_wr_ptr` 0→1 with memory[0]=0xA and `i_ready`=1 → `o_valid`=1 with `o_data`=0xA at the 4th edge; `o_valid`=0 next cycle; `o_b_rd_ptr`=1; `o_empty`=1.
- **Backpressure:** write pointer at 3 (Gray 2), `i_ready`=0 for 10 cycles → exactly one pop; `o_b_rd_ptr`=1; `o_data`=mem[0] stable.
  - Then raise `i_ready` → mem[1] and mem[2] appear on consecutive cycles.
- **Wrap:** stream 20 words (writer advancing, `i_ready`=1) → data emerges in order; `o_b_rd_ptr` wraps 15→0; `o_g_rd_ptr` changes one bit per pop; no pop is taken while `o_empty`=1.
- **Reset mid-stream:** assert `i_rd_rst` while `o_valid`=1 and 4 words are pending → next edge gives `o_valid`=0, `o_empty`=1, pointers 0.
  - After release, with the writer reset to 0, there is no spurious `o_valid`.
